// File: rtl/feeder_pkg.sv
// +----------------------------------------------------------------------+
// | feeder_pkg: shared widths, FSM encodings and sample layout. rev 1.0 |
// +----------------------------------------------------------------------+
`default_nettype none

package feeder_pkg;

  localparam int X_W      = 7;
  localparam int T_W      = 2;
  localparam int EPOCH_W  = 16;
  localparam int SAMPLE_W = 2 * X_W + T_W;

  localparam logic [2:0] IDLE     = 3'd0;
  localparam logic [2:0] START    = 3'd1;
  localparam logic [2:0] WAIT_REQ = 3'd2;
  localparam logic [2:0] FETCH    = 3'd3;
  localparam logic [2:0] PRESENT  = 3'd4;

  typedef struct packed {
    logic [X_W-1:0] x1;
    logic [X_W-1:0] x2;
    logic [T_W-1:0] t;
  } sample_t;

  // Epoch counter sticks at all-ones instead of wrapping back to zero.
  function automatic logic [EPOCH_W-1:0] epoch_sat_inc(input logic [EPOCH_W-1:0] e);
    return (&e) ? e : e + 1'b1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/training_sample_feeder_sample_mem.sv
// +----------------------------------------------------------------------+
// | sample_mem: single-port sync RAM, write-enable, 1-cycle read. rev 1.0|
// +----------------------------------------------------------------------+
`default_nettype none

module sample_mem
  import feeder_pkg::*;
#(
  parameter int DEPTH  = 512,
  parameter int ADDR_W = 9
) (
  input  logic                clk,
  input  logic                we,
  input  logic [ADDR_W-1:0]   addr,
  input  logic [SAMPLE_W-1:0] wdata,
  output logic [SAMPLE_W-1:0] rdata
);

  logic [SAMPLE_W-1:0] r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      r_mem[addr] <= wdata;
    end
    rdata <= r_mem[addr];
  end

endmodule

`default_nettype wire

// File: rtl/training_sample_feeder.sv
// +----------------------------------------------------------------------+
// | training_sample_feeder: buffers (x1,x2,t) samples and serves them to |
// | the neuron epoch after epoch. Option: FEEDER_EPOCH_LIMIT_EN. rev 1.0 |
// +----------------------------------------------------------------------+
`default_nettype none

module training_sample_feeder
  import feeder_pkg::*;
#(
  parameter int DEPTH      = 512,
  parameter int ADDR_W     = 9,
  parameter int MAX_EPOCHS = 1000
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               load_valid,
  input  logic [X_W-1:0]     load_x1,
  input  logic [X_W-1:0]     load_x2,
  input  logic [T_W-1:0]     load_t,
  output logic               load_ready,
  input  logic               clear,
  input  logic               start,
  input  logic               request_flag,
  input  logic               neuron_done,
  output logic               neuron_start,
  output logic [X_W-1:0]     x1_out,
  output logic [X_W-1:0]     x2_out,
  output logic [T_W-1:0]     t_out,
  output logic               data_ready,
  output logic [31:0]        n_samples,
  output logic [EPOCH_W-1:0] epoch_count,
  output logic               busy,
  output logic               timeout
);

  localparam logic [ADDR_W:0]    C_DEPTH = DEPTH[ADDR_W:0];
  localparam logic [ADDR_W:0]    C_ONE   = {{ADDR_W{1'b0}}, 1'b1};

  if (DEPTH > (1 << ADDR_W) || MAX_EPOCHS < 1) begin : g_bad_params
    $error("training_sample_feeder: inconsistent DEPTH/ADDR_W/MAX_EPOCHS");
  end

  logic [2:0]          r_state;
  logic [ADDR_W:0]     r_n;
  logic [ADDR_W-1:0]   r_index;
  logic [EPOCH_W-1:0]  r_epoch;
  logic                r_nstart;
  logic                r_dr;
  sample_t             r_sample;

  logic                w_idle;
  logic                w_we;
  logic [ADDR_W-1:0]   w_addr;
  logic [ADDR_W:0]     w_n_m1;
  logic                w_last;
  logic [EPOCH_W-1:0]  w_epoch_inc;
  sample_t             w_wdata;
  sample_t             w_rdata;

  assign w_idle      = (r_state == IDLE);
  assign w_we        = w_idle && load_valid && !clear && (r_n < C_DEPTH);
  // The single RAM port writes at the fill pointer while idle and reads at index otherwise.
  assign w_addr      = w_idle ? r_n[ADDR_W-1:0] : r_index;
  assign w_n_m1      = r_n - C_ONE;
  assign w_last      = (r_index == w_n_m1[ADDR_W-1:0]);
  assign w_epoch_inc = epoch_sat_inc(r_epoch);
  assign w_wdata     = '{x1: load_x1, x2: load_x2, t: load_t};

  sample_mem #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_mem (
    .clk   (clk),
    .we    (w_we),
    .addr  (w_addr),
    .wdata (w_wdata),
    .rdata (w_rdata)
  );

`ifdef FEEDER_EPOCH_LIMIT_EN
  localparam logic [EPOCH_W-1:0] C_MAX_EPOCHS = MAX_EPOCHS[EPOCH_W-1:0];
  logic r_timeout;
  assign timeout = r_timeout;
`else
  assign timeout = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state  <= IDLE;
      r_n      <= '0;
      r_index  <= '0;
      r_epoch  <= '0;
      r_nstart <= 1'b0;
      r_dr     <= 1'b0;
      r_sample <= '0;
`ifdef FEEDER_EPOCH_LIMIT_EN
      r_timeout <= 1'b0;
`endif
    end else begin
      r_nstart <= 1'b0;
      if (w_idle) begin
        if (clear) begin
          r_n <= '0;
        end else if (w_we) begin
          r_n <= r_n + C_ONE;
        end
        if (start && (r_n != '0)) begin
          r_state  <= START;
          r_nstart <= 1'b1;
          r_index  <= '0;
          r_epoch  <= '0;
`ifdef FEEDER_EPOCH_LIMIT_EN
          r_timeout <= 1'b0;
`endif
        end
      end else begin
        if (r_state == START) begin
          r_state <= WAIT_REQ;
        end
        if (r_state == WAIT_REQ && request_flag) begin
          r_state <= FETCH;
        end
        if (r_state == FETCH) begin
          r_sample <= w_rdata;
          r_dr     <= 1'b1;
          r_state  <= PRESENT;
        end
        // Handshake completion advances the pointer even if done lands in the same cycle.
        if (r_state == PRESENT && !request_flag) begin
          r_dr    <= 1'b0;
          r_state <= WAIT_REQ;
          if (w_last) begin
            r_index <= '0;
            r_epoch <= w_epoch_inc;
`ifdef FEEDER_EPOCH_LIMIT_EN
            if (w_epoch_inc >= C_MAX_EPOCHS) begin
              r_timeout <= 1'b1;
              r_state   <= IDLE;
            end
`endif
          end else begin
            r_index <= r_index + 1'b1;
          end
        end
        if (r_state > PRESENT) begin
          r_state <= IDLE;
        end
        if (neuron_done) begin
          r_state <= IDLE;
          r_dr    <= 1'b0;
        end
      end
    end
  end

  assign load_ready   = w_idle && (r_n < C_DEPTH);
  assign busy         = !w_idle;
  assign neuron_start = r_nstart;
  assign data_ready   = r_dr;
  assign x1_out       = r_sample.x1;
  assign x2_out       = r_sample.x2;
  assign t_out        = r_sample.t;
  assign epoch_count  = r_epoch;
  assign n_samples    = {{(31 - ADDR_W){1'b0}}, r_n};

endmodule

`default_nettype wire
